// File: rtl/apb_ram_arbiter_pkg.sv
// Shared types and defaults for the APB RAM arbiter slice.
package apb_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int DEF_AW             = 32;
  localparam int DEF_DW             = 8;
  localparam int DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/apb_ram_arbiter_if.sv
// APB bus between the arbiter (master) and the 16x8 RAM (slave).
interface apb_ram_arbiter_if
  import apb_ram_arbiter_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) ();

  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_ram_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches from last+1 upward, wrapping.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NREQ]) begin
        gnt = '0;
        gnt[(int'(last) + k) % NREQ] = 1'b1;
        idx = IW'((int'(last) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/apb_ram_arbiter.sv
// Round-robin APB master sharing one APB RAM among NREQ requesters.
// Optional ACCESS-phase timeout: define APB_RAM_ARBITER_TIMEOUT_EN.
module apb_ram_arbiter
  import apb_ram_arbiter_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int AW             = DEF_AW,
  parameter int DW             = DEF_DW,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_err,
  apb_ram_arbiter_if.master apb,
  output state_t            dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("apb_ram_arbiter: parameter out of range");
  end

  // Requester handshake: req[i] is held high until done[i] pulses for one
  // cycle; the command fields are sampled only in the cycle the grant is made.
  state_t            state_q, state_n;
  logic [IW-1:0]     last_q, last_n;
  logic [NREQ-1:0]   gnt_q, gnt_n;
  logic [NREQ-1:0]   done_q, done_n;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_n;
  logic              rsp_err_q, rsp_err_n;
  logic [AW-1:0]     paddr_q, paddr_n;
  logic              pwrite_q, pwrite_n;
  logic [DW-1:0]     pwdata_q, pwdata_n;
  logic              psel_q, psel_n;
  logic              penable_q, penable_n;
  logic [NREQ-1:0]   req_eff;
  logic [NREQ-1:0]   arb_gnt;
  logic [IW-1:0]     arb_idx;

`ifdef APB_RAM_ARBITER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_n;
`endif

  // The owner's req is still high in its done cycle; it is stale, not a new request.
  assign req_eff = req & ~done_q;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req  (req_eff),
    .last (last_q),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      last_q      <= IW'(NREQ - 1);
      gnt_q       <= '0;
      done_q      <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
`ifdef APB_RAM_ARBITER_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_n;
      last_q      <= last_n;
      gnt_q       <= gnt_n;
      done_q      <= done_n;
      rsp_rdata_q <= rsp_rdata_n;
      rsp_err_q   <= rsp_err_n;
      paddr_q     <= paddr_n;
      pwrite_q    <= pwrite_n;
      pwdata_q    <= pwdata_n;
      psel_q      <= psel_n;
      penable_q   <= penable_n;
`ifdef APB_RAM_ARBITER_TIMEOUT_EN
      tmo_q       <= tmo_n;
`endif
    end
  end

  always_comb begin
    state_n     = state_q;
    last_n      = last_q;
    gnt_n       = gnt_q;
    done_n      = '0;
    rsp_rdata_n = rsp_rdata_q;
    rsp_err_n   = rsp_err_q;
    paddr_n     = paddr_q;
    pwrite_n    = pwrite_q;
    pwdata_n    = pwdata_q;
    psel_n      = psel_q;
    penable_n   = penable_q;
`ifdef APB_RAM_ARBITER_TIMEOUT_EN
    tmo_n       = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_eff) begin
          paddr_n  = req_addr[int'(arb_idx)*AW +: AW];
          pwdata_n = req_wdata[int'(arb_idx)*DW +: DW];
          pwrite_n = req_write[arb_idx];
          gnt_n    = arb_gnt;
          last_n   = arb_idx;
          psel_n   = 1'b1;
          state_n  = SETUP;
        end
      end
      SETUP: begin
        penable_n = 1'b1;
        state_n   = ACCESS;
`ifdef APB_RAM_ARBITER_TIMEOUT_EN
        tmo_n     = '0;
`endif
      end
      ACCESS: begin
        if (apb.pready) begin
          rsp_rdata_n = pwrite_q ? '0 : apb.prdata;
          rsp_err_n   = apb.pslverr;
          done_n      = gnt_q;
          gnt_n       = '0;
          psel_n      = 1'b0;
          penable_n   = 1'b0;
          state_n     = IDLE;
        end
`ifdef APB_RAM_ARBITER_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rsp_rdata_n = '0;
          rsp_err_n   = 1'b1;
          done_n      = gnt_q;
          gnt_n       = '0;
          psel_n      = 1'b0;
          penable_n   = 1'b0;
          state_n     = IDLE;
        end else begin
          tmo_n = tmo_q + TW'(1);
        end
`endif
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.pwdata  = pwdata_q;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign dbg_state   = state_q;

endmodule
